signed_div_ctrl: RTL

//  Iterative signed 32-bit divider controller for the processor multdiv path.

---
 rtl/signed_div_ctrl_if.sv | 43 ++++
 rtl/signed_div_ctrl.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/signed_div_ctrl_if.sv
// Handshake/bus bundle between the pipeline and the iterative signed divider.
// Latency: pure wiring, no storage.
// Backpressure: none; ctrl_DIV is a start pulse, data_resultRDY a completion pulse.
// Optional DIV_REMAINDER_EN adds the data_remainder signal.
interface signed_div_ctrl_if #(
    parameter int WIDTH = 32
);
    logic             ctrl_DIV;
    logic [WIDTH-1:0] data_operandA;
    logic [WIDTH-1:0] data_operandB;
    logic [WIDTH-1:0] data_result;
    logic             data_exception;
    logic             data_resultRDY;
`ifdef DIV_REMAINDER_EN
    logic [WIDTH-1:0] data_remainder;
`endif

    // Pipeline side: issues starts and operands, consumes results.
    modport master (
        output ctrl_DIV,
        output data_operandA,
        output data_operandB,
        input  data_result,
        input  data_exception,
`ifdef DIV_REMAINDER_EN
        input  data_remainder,
`endif
        input  data_resultRDY
    );

    // Divider side.
    modport slave (
        input  ctrl_DIV,
        input  data_operandA,
        input  data_operandB,
        output data_result,
        output data_exception,
`ifdef DIV_REMAINDER_EN
        output data_remainder,
`endif
        output data_resultRDY
    );
endinterface

// File: rtl/signed_div_ctrl.sv
// Iterative signed divider: restoring shift/subtract, truncating toward zero.
// Latency: RDY pulses the cycle after the 34th edge past the start edge (div-by-zero: the next cycle).
// Backpressure: none; a new start at any time aborts and restarts. Option macro: DIV_REMAINDER_EN.
module signed_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic              clock,
    input  logic              reset,
    signed_div_ctrl_if.slave  bus
);
    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_ABS  = 3'd1;
    localparam logic [2:0] ST_ITER = 3'd2;
    localparam logic [2:0] ST_FIX  = 3'd3;
    localparam logic [2:0] ST_DONE = 3'd4;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO    = '0;
    localparam logic [WIDTH-1:0] ALL1    = '1;
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [CNT_W-1:0] LAST    = CNT_W'(WIDTH - 1);

    // Two's complement negation: bitwise inverter followed by +1.
    function automatic logic [WIDTH-1:0] neg(input logic [WIDTH-1:0] x);
        return (~x) + ONE;
    endfunction

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // a_q holds the dividend, then |A|, and is shifted into the quotient.
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic             sign_q, sign_d;
    logic             ovf_q, ovf_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             exc_q, exc_d;
    logic             rdy_q, rdy_d;
`ifdef DIV_REMAINDER_EN
    logic             a_neg_q, a_neg_d;
    logic [WIDTH-1:0] remout_q, remout_d;
`endif

    logic [2*WIDTH-1:0] shift_w;
    logic [WIDTH-1:0]   rem_sh;

    // Next-state and datapath sequencing; a start overrides whatever is in flight.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        sign_d   = sign_q;
        ovf_d    = ovf_q;
        result_d = result_q;
        exc_d    = exc_q;
        rdy_d    = 1'b0;
`ifdef DIV_REMAINDER_EN
        a_neg_d  = a_neg_q;
        remout_d = remout_q;
`endif
        shift_w  = {rem_q, a_q} << 1;
        rem_sh   = shift_w[2*WIDTH-1:WIDTH];

        case (state_q)
            ST_ABS: begin
                // |0x80000000| stays as unsigned 2^31 in WIDTH bits.
                a_d     = a_q[WIDTH-1] ? neg(a_q) : a_q;
                b_d     = b_q[WIDTH-1] ? neg(b_q) : b_q;
                rem_d   = ZERO;
                cnt_d   = '0;
                state_d = ST_ITER;
            end
            ST_ITER: begin
                // rem < |B| <= 2^31, so the shifted remainder never exceeds WIDTH bits.
                if (rem_sh >= b_q) begin
                    rem_d = rem_sh - b_q;
                    a_d   = shift_w[WIDTH-1:0] | ONE;
                end else begin
                    rem_d = rem_sh;
                    a_d   = shift_w[WIDTH-1:0];
                end
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == LAST) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                result_d = sign_q ? neg(a_q) : a_q;
                exc_d    = ovf_q;
`ifdef DIV_REMAINDER_EN
                remout_d = ovf_q ? ZERO : (a_neg_q ? neg(rem_q) : rem_q);
`endif
                rdy_d    = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (bus.ctrl_DIV) begin
            a_d    = bus.data_operandA;
            b_d    = bus.data_operandB;
            sign_d = bus.data_operandA[WIDTH-1] ^ bus.data_operandB[WIDTH-1];
            ovf_d  = (bus.data_operandA == MIN_NEG) && (bus.data_operandB == ALL1);
            exc_d  = 1'b0;
            cnt_d  = '0;
`ifdef DIV_REMAINDER_EN
            a_neg_d = bus.data_operandA[WIDTH-1];
`endif
            if (bus.data_operandB == ZERO) begin
                result_d = ZERO;
                exc_d    = 1'b1;
                rdy_d    = 1'b1;
`ifdef DIV_REMAINDER_EN
                remout_d = ZERO;
`endif
                state_d  = ST_DONE;
            end else begin
                rdy_d    = 1'b0;
                state_d  = ST_ABS;
            end
        end
    end

    // State registers; reset aborts any divide and clears all outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            sign_q   <= 1'b0;
            ovf_q    <= 1'b0;
            result_q <= '0;
            exc_q    <= 1'b0;
            rdy_q    <= 1'b0;
`ifdef DIV_REMAINDER_EN
            a_neg_q  <= 1'b0;
            remout_q <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            sign_q   <= sign_d;
            ovf_q    <= ovf_d;
            result_q <= result_d;
            exc_q    <= exc_d;
            rdy_q    <= rdy_d;
`ifdef DIV_REMAINDER_EN
            a_neg_q  <= a_neg_d;
            remout_q <= remout_d;
`endif
        end
    end

    assign bus.data_result    = result_q;
    assign bus.data_exception = exc_q;
    assign bus.data_resultRDY = rdy_q;
`ifdef DIV_REMAINDER_EN
    assign bus.data_remainder = remout_q;
`endif

endmodule
